// File: rtl/simmem_pkg.sv
// Shared types for the simulated memory controller.
// Write response layout, bank sizing and slot states.
package simmem_pkg;

    localparam int unsigned NumIds = 16;
    localparam int unsigned IDWidth = $clog2(NumIds);

    localparam int unsigned WriteRespBankTotalCapacity = 32;
    localparam int unsigned WriteRespBankAddrWidth =
        $clog2(WriteRespBankTotalCapacity);

    typedef struct packed {
        logic [IDWidth-1:0] id;
        logic [1:0]         resp;
        logic [7:0]         user;
    } write_resp_t;

    localparam int unsigned WriteRespWidth = $bits(write_resp_t);

    typedef struct packed {
        logic [WriteRespBankAddrWidth-1:0] nxt_elem;
    } write_resp_metadata_e;

    typedef enum logic [1:0] {
        FREE,
        RESERVED,
        FILLED
    } slot_state_e;

endpackage

// File: rtl/simmem_prio_enc.sv
// Lowest-set-bit finder.
// Reports the index of the lowest request and whether any is set.
module simmem_prio_enc #(
    parameter int unsigned Width    = 8,
    parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0]    req_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    // Scan from the top so the lowest set bit is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxWidth'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_write_resp_bank.sv
// Write response bank: holds responses until released.
// Per-ID linked lists keep responses in reservation order.
module simmem_write_resp_bank
    import simmem_pkg::*;
#(
    parameter int unsigned TotalCapacity = WriteRespBankTotalCapacity,
    parameter int unsigned AddrWidth     = $clog2(TotalCapacity)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IDWidth-1:0]        res_id_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    output logic [AddrWidth-1:0]      res_addr_o,
    input  logic [WriteRespWidth-1:0] in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [AddrWidth-1:0]      rel_addr_i,
    input  logic                      rel_valid_i,
    output logic [WriteRespWidth-1:0] out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    localparam int unsigned CntW = AddrWidth + 1;

    slot_state_e          state_q [TotalCapacity];
    logic [TotalCapacity-1:0] rel_q;
    write_resp_t          data_q  [TotalCapacity];
    write_resp_metadata_e nxt_q   [TotalCapacity];

    logic [AddrWidth-1:0] head_q [NumIds];
    logic [AddrWidth-1:0] head_d [NumIds];
    logic [AddrWidth-1:0] tail_q [NumIds];
    logic [AddrWidth-1:0] tail_d [NumIds];
    logic [AddrWidth-1:0] fill_q [NumIds];
    logic [AddrWidth-1:0] fill_d [NumIds];
    logic [CntW-1:0]      unf_q  [NumIds];
    logic [CntW-1:0]      unf_d  [NumIds];
    logic [CntW-1:0]      fil_q  [NumIds];
    logic [CntW-1:0]      fil_d  [NumIds];
    logic [CntW-1:0]      lst_cnt [NumIds];

    logic [TotalCapacity-1:0] free_vec;
    logic [AddrWidth-1:0]     free_idx;
    logic                     free_any;

    logic [NumIds-1:0]    cand_vec;
    logic [IDWidth-1:0]   out_id;
    logic [AddrWidth-1:0] out_addr;

    write_resp_t        in_resp;
    logic [IDWidth-1:0] in_id;

    logic res_hs;
    logic in_hs;
    logic out_hs;

    logic [NumIds-1:0] res_me;
    logic [NumIds-1:0] in_me;
    logic [NumIds-1:0] out_me;

    function automatic logic [CntW-1:0] cnt_step(
        input logic [CntW-1:0] c,
        input logic            inc,
        input logic            dec
    );
        logic [CntW-1:0] r;
        r = c;
        if (inc && !dec && c != CntW'(TotalCapacity)) begin
            r = c + CntW'(1);
        end else if (dec && !inc && c != '0) begin
            r = c - CntW'(1);
        end
        return r;
    endfunction

    // Free-slot map and per-ID output eligibility.
    always_comb begin
        free_vec = '0;
        cand_vec = '0;
        for (int i = 0; i < TotalCapacity; i++) begin
            free_vec[i] = (state_q[i] == FREE);
        end
        for (int i = 0; i < NumIds; i++) begin
            cand_vec[i] = (fil_q[i] != '0)
                && (state_q[head_q[i]] == FILLED)
                && rel_q[head_q[i]];
        end
    end

    simmem_prio_enc #(
        .Width    (TotalCapacity),
        .IdxWidth (AddrWidth)
    ) u_free_enc (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .valid_o (free_any)
    );

    simmem_prio_enc #(
        .Width    (NumIds),
        .IdxWidth (IDWidth)
    ) u_out_enc (
        .req_i   (cand_vec),
        .idx_o   (out_id),
        .valid_o (out_valid_o)
    );

    assign res_ready_o = free_any;
    assign res_addr_o  = free_idx;
    assign res_hs      = res_valid_i & free_any;

    assign in_resp    = write_resp_t'(in_data_i);
    assign in_id      = in_resp.id;
    assign in_ready_o = (unf_q[in_id] != '0);
    assign in_hs      = in_valid_i & in_ready_o;

    assign out_addr   = head_q[out_id];
    assign out_data_o = out_valid_o ? data_q[out_addr] : '0;
    assign out_hs     = out_valid_o & out_ready_i;

    // Per-ID pointer and count updates; tail, fill, head move independently.
    always_comb begin
        res_me = '0;
        in_me  = '0;
        out_me = '0;
        for (int i = 0; i < NumIds; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            fill_d[i]  = fill_q[i];
            lst_cnt[i] = unf_q[i] + fil_q[i];
            res_me[i]  = res_hs && (res_id_i == IDWidth'(i));
            in_me[i]   = in_hs && (in_id == IDWidth'(i));
            out_me[i]  = out_hs && (out_id == IDWidth'(i));
            if (res_me[i]) begin
                tail_d[i] = free_idx;
                if (lst_cnt[i] == '0) begin
                    head_d[i] = free_idx;
                end
                if (unf_q[i] == '0) begin
                    fill_d[i] = free_idx;
                end
            end
            if (in_me[i]) begin
                if (unf_q[i] != CntW'(1)) begin
                    fill_d[i] = nxt_q[fill_q[i]].nxt_elem;
                end else if (res_me[i]) begin
                    fill_d[i] = free_idx;
                end
            end
            if (out_me[i]) begin
                if (lst_cnt[i] != CntW'(1)) begin
                    head_d[i] = nxt_q[head_q[i]].nxt_elem;
                end else if (res_me[i]) begin
                    head_d[i] = free_idx;
                end
            end
            unf_d[i] = cnt_step(unf_q[i], res_me[i], in_me[i]);
            fil_d[i] = cnt_step(fil_q[i], in_me[i], out_me[i]);
        end
    end

    // Per-ID list registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                fill_q[i] <= '0;
                unf_q[i]  <= '0;
                fil_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                fill_q[i] <= fill_d[i];
                unf_q[i]  <= unf_d[i];
                fil_q[i]  <= fil_d[i];
            end
        end
    end

    // Slot state, released bits, payload and next-pointer memory.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rel_q <= '0;
            for (int i = 0; i < TotalCapacity; i++) begin
                state_q[i] <= FREE;
                data_q[i]  <= '0;
                nxt_q[i]   <= '0;
            end
        end else begin
            if (rel_valid_i && state_q[rel_addr_i] != FREE) begin
                rel_q[rel_addr_i] <= 1'b1;
            end
            if (res_hs) begin
                state_q[free_idx] <= RESERVED;
                if (lst_cnt[res_id_i] != '0) begin
                    nxt_q[tail_q[res_id_i]].nxt_elem <= free_idx;
                end
            end
            if (in_hs) begin
                data_q[fill_q[in_id]]  <= in_resp;
                state_q[fill_q[in_id]] <= FILLED;
            end
            if (out_hs) begin
                state_q[out_addr] <= FREE;
                rel_q[out_addr]   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simmem_write_resp_bank.sv
// Bench for the write response bank.
// Directed scenarios plus random traffic against a queue model.
module tb_simmem_write_resp_bank;
    import simmem_pkg::*;

    localparam int Cap = WriteRespBankTotalCapacity;
    localparam int AW  = WriteRespBankAddrWidth;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic [IDWidth-1:0] res_id;
    logic res_valid;
    logic res_ready;
    logic [AW-1:0] res_addr;
    write_resp_t in_data;
    logic in_valid;
    logic in_ready;
    logic [AW-1:0] rel_addr;
    logic rel_valid;
    logic [WriteRespWidth-1:0] out_raw;
    write_resp_t out_data;
    logic out_valid;
    logic out_ready;

    assign out_data = write_resp_t'(out_raw);

    int m_state [Cap];
    bit m_rel [Cap];
    write_resp_t m_data [Cap];
    int q [NumIds][$];

    bit e_res_ready;
    int e_res_addr;
    bit e_in_ready;
    bit e_out_valid;
    int e_out_id;
    write_resp_t e_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    simmem_write_resp_bank dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .res_id_i    (res_id),
        .res_valid_i (res_valid),
        .res_ready_o (res_ready),
        .res_addr_o  (res_addr),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .rel_addr_i  (rel_addr),
        .rel_valid_i (rel_valid),
        .out_data_o  (out_raw),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    task automatic model_reset();
        for (int k = 0; k < Cap; k++) begin
            m_state[k] = 0;
            m_rel[k] = 0;
            m_data[k] = '0;
        end
        for (int k = 0; k < NumIds; k++) q[k].delete();
    endtask

    task automatic calc_exp();
        int id;
        e_res_ready = 0;
        e_res_addr = 0;
        for (int k = Cap - 1; k >= 0; k--) begin
            if (m_state[k] == 0) begin
                e_res_ready = 1;
                e_res_addr = k;
            end
        end
        id = int'(in_data.id);
        e_in_ready = 0;
        for (int k = 0; k < q[id].size(); k++) begin
            if (m_state[q[id][k]] == 1) e_in_ready = 1;
        end
        e_out_valid = 0;
        e_out_id = 0;
        e_out_data = '0;
        for (int k = NumIds - 1; k >= 0; k--) begin
            if (q[k].size() > 0) begin
                if (m_state[q[k][0]] == 2 && m_rel[q[k][0]]) begin
                    e_out_valid = 1;
                    e_out_id = k;
                    e_out_data = m_data[q[k][0]];
                end
            end
        end
    endtask

    task automatic drive(input bit rv, input int rid, input bit iv,
                         input write_resp_t d, input bit lv,
                         input int la, input bit ordy);
        @(negedge clk_i);
        res_valid = rv;
        res_id = rid[IDWidth-1:0];
        in_valid = iv;
        in_data = d;
        rel_valid = lv;
        rel_addr = la[AW-1:0];
        out_ready = ordy;
        #1;
        calc_exp();
    endtask

    task automatic idle(input bit ordy);
        drive(0, 0, 0, '0, 0, 0, ordy);
    endtask

    task automatic commit();
        bit done;
        int id;
        int a;
        @(posedge clk_i);
        if (rel_valid && m_state[rel_addr] != 0) m_rel[rel_addr] = 1;
        if (in_valid && e_in_ready) begin
            id = int'(in_data.id);
            done = 0;
            for (int k = 0; k < q[id].size(); k++) begin
                if (!done && m_state[q[id][k]] == 1) begin
                    m_state[q[id][k]] = 2;
                    m_data[q[id][k]] = in_data;
                    done = 1;
                end
            end
        end
        if (e_out_valid && out_ready) begin
            a = q[e_out_id].pop_front();
            m_state[a] = 0;
            m_rel[a] = 0;
        end
        if (res_valid && e_res_ready) begin
            m_state[e_res_addr] = 1;
            m_rel[e_res_addr] = 0;
            q[int'(res_id)].push_back(e_res_addr);
        end
    endtask

    function automatic write_resp_t mk(input int id);
        write_resp_t d;
        d.id = id[IDWidth-1:0];
        d.resp = 2'($urandom);
        d.user = 8'($urandom);
        return d;
    endfunction

    function automatic int pick_id();
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, NumIds - 1);
        return $urandom_range(0, 3);
    endfunction

    function automatic bit model_empty();
        for (int k = 0; k < Cap; k++) if (m_state[k] != 0) return 0;
        return 1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        res_valid = 0; res_id = '0; in_valid = 0; in_data = '0;
        rel_valid = 0; rel_addr = '0; out_ready = 0;
        model_reset();
        #3;
        n_cmp++;
        if (out_valid !== 1'b0 || out_raw !== '0) begin
            n_bad++;
            $display("FAIL reset_out valid=%b data=%h need 0/0", out_valid, out_raw);
        end
        n_cmp++;
        if (res_ready !== 1'b1 || res_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_res ready=%b addr=%0d need 1/0", res_ready, res_addr);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in ready=%b need 0", in_ready);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || res_ready !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset ov=%b rr=%b ir=%b need 0/1/0",
                     out_valid, res_ready, in_ready);
        end
    endtask

    task automatic test_drain();
        int c = 0;
        while (!model_empty() && c < 400) begin
            drive(0, 0, 1, mk(c % NumIds), 1, c % Cap, 1);
            commit();
            c++;
        end
        idle(0);
        n_cmp++;
        if (c >= 400 || out_valid !== 1'b0 || res_ready !== 1'b1 || res_addr !== '0) begin
            n_bad++;
            $display("FAIL drain cycles=%0d ov=%b rr=%b addr=%0d need empty bank",
                     c, out_valid, res_ready, res_addr);
        end
        commit();
    endtask

    task automatic test_basic();
        write_resp_t d;
        d = mk(3);
        d.resp = 2'd0;
        drive(1, 3, 0, '0, 0, 0, 0);
        n_cmp++;
        if (res_ready !== 1'b1 || res_addr !== '0) begin
            n_bad++;
            $display("FAIL basic_res rr=%b addr=%0d need 1/0", res_ready, res_addr);
        end
        commit();
        drive(0, 0, 1, d, 0, 0, 0);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_in_ready got=%b need 1", in_ready);
        end
        commit();
        drive(0, 0, 0, '0, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_early_out got=%b need 0", out_valid);
        end
        commit();
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            n_bad++;
            $display("FAIL basic_out ov=%b data=%h need 1/%h", out_valid, out_data, d);
        end
        commit();
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b0 || res_addr !== '0) begin
            n_bad++;
            $display("FAIL basic_freed ov=%b addr=%0d need 0/0", out_valid, res_addr);
        end
        commit();
    endtask

    task automatic test_order();
        write_resp_t d [3];
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 0, '0, 0, 0, 0);
            n_cmp++;
            if (res_addr !== AW'(k)) begin
                n_bad++;
                $display("FAIL order_res%0d addr=%0d need %0d", k, res_addr, k);
            end
            commit();
        end
        for (int k = 0; k < 3; k++) begin
            d[k] = mk(5);
            drive(0, 0, 1, d[k], 0, 0, 0);
            commit();
        end
        drive(0, 0, 0, '0, 1, 2, 0); commit();
        drive(0, 0, 0, '0, 1, 0, 0); commit();
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== d[0]) begin
            n_bad++;
            $display("FAIL order_a ov=%b data=%h need 1/%h", out_valid, out_data, d[0]);
        end
        commit();
        for (int k = 0; k < 2; k++) begin
            idle(1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL order_b_wait ov=%b need 0", out_valid);
            end
            commit();
        end
        drive(0, 0, 0, '0, 1, 1, 0); commit();
        for (int k = 1; k < 3; k++) begin
            idle(1);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== d[k]) begin
                n_bad++;
                $display("FAIL order_%0d ov=%b data=%h need 1/%h",
                         k, out_valid, out_data, d[k]);
            end
            commit();
        end
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL order_end ov=%b need 0", out_valid);
        end
        commit();
    endtask

    task automatic test_full();
        for (int k = 0; k < Cap; k++) begin
            drive(1, k % NumIds, 0, '0, 0, 0, 0);
            n_cmp++;
            if (res_ready !== 1'b1 || res_addr !== AW'(k)) begin
                n_bad++;
                $display("FAIL full_res%0d rr=%b addr=%0d need 1/%0d",
                         k, res_ready, res_addr, k);
            end
            commit();
        end
        drive(1, 0, 0, '0, 0, 0, 0);
        n_cmp++;
        if (res_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_33rd rr=%b need 0", res_ready);
        end
        commit();
        drive(0, 0, 1, mk(7), 0, 0, 0); commit();
        drive(0, 0, 0, '0, 1, 7, 0); commit();
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data.id !== 4'(7)) begin
            n_bad++;
            $display("FAIL full_out ov=%b id=%0d need 1/7", out_valid, out_data.id);
        end
        commit();
        idle(0);
        n_cmp++;
        if (res_ready !== 1'b1 || res_addr !== AW'(7)) begin
            n_bad++;
            $display("FAIL full_regrant rr=%b addr=%0d need 1/7", res_ready, res_addr);
        end
        commit();
        test_drain();
    endtask

    task automatic test_ignore();
        drive(0, 0, 1, mk(7), 0, 0, 0);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_fill ir=%b need 0", in_ready);
        end
        commit();
        drive(0, 0, 0, '0, 1, 10, 0); commit();
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b0 || res_addr !== '0) begin
            n_bad++;
            $display("FAIL ign_state ov=%b addr=%0d need 0/0", out_valid, res_addr);
        end
        commit();
        for (int k = 0; k <= 10; k++) begin
            drive(1, k, 0, '0, 0, 0, 0); commit();
        end
        drive(0, 0, 1, mk(10), 0, 0, 0); commit();
        for (int k = 0; k < 2; k++) begin
            idle(0);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL ign_prerel ov=%b need 0", out_valid);
            end
            commit();
        end
        drive(0, 0, 0, '0, 1, 10, 0); commit();
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data.id !== 4'(10)) begin
            n_bad++;
            $display("FAIL ign_rel ov=%b id=%0d need 1/10", out_valid, out_data.id);
        end
        commit();
        test_drain();
    endtask

    task automatic test_prio();
        drive(1, 9, 0, '0, 0, 0, 0); commit();
        drive(1, 2, 0, '0, 0, 0, 0); commit();
        drive(0, 0, 1, mk(9), 0, 0, 0); commit();
        drive(0, 0, 1, mk(2), 0, 0, 0); commit();
        drive(0, 0, 0, '0, 1, 1, 0); commit();
        drive(0, 0, 0, '0, 1, 0, 0); commit();
        for (int k = 0; k < 3; k++) begin
            idle(0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data.id !== 4'(2)) begin
                n_bad++;
                $display("FAIL prio_hold%0d ov=%b id=%0d need 1/2",
                         k, out_valid, out_data.id);
            end
            commit();
        end
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data.id !== 4'(2)) begin
            n_bad++;
            $display("FAIL prio_first ov=%b id=%0d need 1/2", out_valid, out_data.id);
        end
        commit();
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data.id !== 4'(9)) begin
            n_bad++;
            $display("FAIL prio_second ov=%b id=%0d need 1/9", out_valid, out_data.id);
        end
        commit();
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_end ov=%b need 0", out_valid);
        end
        commit();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            drive(1, k * 3, 0, '0, 0, 0, 0); commit();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1, mk(k * 3), 1, k, 0); commit();
        end
        idle(0);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_pre ov=%b need 1", out_valid);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_raw !== '0) begin
            n_bad++;
            $display("FAIL rmid_async ov=%b data=%h need 0/0", out_valid, out_raw);
        end
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(0);
        n_cmp++;
        if (res_ready !== 1'b1 || res_addr !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_after rr=%b addr=%0d ov=%b need 1/0/0",
                     res_ready, res_addr, out_valid);
        end
        commit();
        for (int k = 0; k < NumIds; k++) begin
            drive(0, 0, 1, mk(k), 0, 0, 0);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL rmid_list%0d ir=%b need 0", k, in_ready);
            end
            commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(0, 1), pick_id(),
                  $urandom_range(0, 4) < 3, mk(pick_id()),
                  $urandom_range(0, 1), $urandom_range(0, Cap - 1),
                  $urandom_range(0, 9) < 7);
            n_cmp++;
            if (res_ready !== e_res_ready) begin
                n_bad++;
                $display("FAIL rnd_res_ready c=%0d got=%b need %b", c, res_ready, e_res_ready);
            end
            if (e_res_ready) begin
                n_cmp++;
                if (res_addr !== AW'(e_res_addr)) begin
                    n_bad++;
                    $display("FAIL rnd_res_addr c=%0d got=%0d need %0d",
                             c, res_addr, e_res_addr);
                end
            end
            n_cmp++;
            if (in_ready !== e_in_ready) begin
                n_bad++;
                $display("FAIL rnd_in_ready c=%0d got=%b need %b", c, in_ready, e_in_ready);
            end
            n_cmp++;
            if (out_valid !== e_out_valid) begin
                n_bad++;
                $display("FAIL rnd_out_valid c=%0d got=%b need %b",
                         c, out_valid, e_out_valid);
            end
            if (e_out_valid) begin
                n_cmp++;
                if (out_data !== e_out_data) begin
                    n_bad++;
                    $display("FAIL rnd_out_data c=%0d got=%h need %h",
                             c, out_data, e_out_data);
                end
            end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_full();
        test_ignore();
        test_prio();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
